// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_unit
// Purpose  : Memory-stage load unit. Accepts one load request at a time, runs
//            a request/acknowledge transaction on the data-memory port, then
//            extracts and sign/zero-extends the addressed byte, halfword or
//            word into a registered result for the writeback mux. Flags
//            misaligned/illegal-size requests and bus faults.
// Ports    : clk_in, rst_in (sync, active-high)
//            load_req_in, load_size_in, load_unsigned_in, addr_in, flush_in
//            dmem_req_o, dmem_addr_o, dmem_ack_in, dmem_rdata_in, dmem_err_in
//            load_output_o, load_valid_o, misaligned_o, access_fault_o, stall_o
// Config   : LOAD_TIMEOUT_EN - when defined, a WAIT that lasts TIMEOUT_CYCLES
//            cycles without ack is abandoned and reported as an access fault.
// Revision : 1.0 - initial release
// ============================================================================
module load_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        load_req_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [31:0] addr_in,
    input  logic        flush_in,
    output logic        dmem_req_o,
    output logic [31:0] dmem_addr_o,
    input  logic        dmem_ack_in,
    input  logic [31:0] dmem_rdata_in,
    input  logic        dmem_err_in,
    output logic [31:0] load_output_o,
    output logic        load_valid_o,
    output logic        misaligned_o,
    output logic        access_fault_o,
    output logic        stall_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  r_state;
    logic [29:0] r_word_addr;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_kill;
    logic [31:0] r_load_output;
    logic        r_load_valid;
    logic        r_misaligned;
    logic        r_access_fault;

    logic [0:0]  w_state_next;
    logic        w_kill_next;
    logic [31:0] w_output_next;
    logic        w_valid_next;
    logic        w_misaligned_next;
    logic        w_fault_next;
    logic        w_latch;
    logic        w_misaligned;
    logic        w_discard;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_extracted;

`ifdef LOAD_TIMEOUT_EN
    localparam logic [7:0] c_timeout = TIMEOUT_CYCLES[7:0];
    logic [7:0] r_timeout_cnt;
    logic [7:0] w_cnt_next;
    assign w_cnt_next = r_timeout_cnt + 8'd1;
`endif

    // Size 11 is illegal and treated exactly like a misaligned access.
    assign w_misaligned = ((load_size_in == 2'b01) && addr_in[0])
                        || ((load_size_in == 2'b10) && (addr_in[1:0] != 2'b00))
                        || (load_size_in == 2'b11);

    // A flush arriving on the ack cycle itself also discards the result.
    assign w_discard = r_kill || flush_in;

    always_comb begin
        w_byte = dmem_rdata_in[7:0];
        case (r_lane)
            2'd0: w_byte = dmem_rdata_in[7:0];
            2'd1: w_byte = dmem_rdata_in[15:8];
            2'd2: w_byte = dmem_rdata_in[23:16];
            2'd3: w_byte = dmem_rdata_in[31:24];
            default: w_byte = dmem_rdata_in[7:0];
        endcase
        w_half = r_lane[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
        case (r_size)
            2'b00:   w_extracted = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
            2'b01:   w_extracted = {{16{w_half[15] & ~r_unsigned}}, w_half};
            default: w_extracted = dmem_rdata_in;
        endcase
    end

    always_comb begin
        w_state_next      = r_state;
        w_kill_next       = r_kill;
        w_output_next     = r_load_output;
        w_valid_next      = 1'b0;
        w_misaligned_next = 1'b0;
        w_fault_next      = 1'b0;
        w_latch           = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_kill_next = 1'b0;
                if (load_req_in && !flush_in) begin
                    if (w_misaligned) begin
                        w_misaligned_next = 1'b1;
                    end else begin
                        w_latch      = 1'b1;
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_ack_in) begin
                    w_state_next = S_IDLE;
                    w_kill_next  = 1'b0;
                    if (!w_discard) begin
                        if (dmem_err_in) begin
                            w_fault_next  = 1'b1;
                            w_output_next = 32'd0;
                        end else begin
                            w_valid_next  = 1'b1;
                            w_output_next = w_extracted;
                        end
                    end
                end else begin
                    if (flush_in) begin
                        w_kill_next = 1'b1;
                    end
`ifdef LOAD_TIMEOUT_EN
                    // Ack has priority; expiry only applies on a no-ack cycle.
                    if (w_cnt_next == c_timeout) begin
                        w_state_next  = S_IDLE;
                        w_kill_next   = 1'b0;
                        w_output_next = 32'd0;
                        w_fault_next  = !w_discard;
                    end
`endif
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state        <= S_IDLE;
            r_word_addr    <= 30'd0;
            r_lane         <= 2'd0;
            r_size         <= 2'd0;
            r_unsigned     <= 1'b0;
            r_kill         <= 1'b0;
            r_load_output  <= 32'd0;
            r_load_valid   <= 1'b0;
            r_misaligned   <= 1'b0;
            r_access_fault <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_kill         <= w_kill_next;
            r_load_output  <= w_output_next;
            r_load_valid   <= w_valid_next;
            r_misaligned   <= w_misaligned_next;
            r_access_fault <= w_fault_next;
            if (w_latch) begin
                r_word_addr <= addr_in[31:2];
                r_lane      <= addr_in[1:0];
                r_size      <= load_size_in;
                r_unsigned  <= load_unsigned_in;
            end
        end
    end

`ifdef LOAD_TIMEOUT_EN
    always_ff @(posedge clk_in) begin
        if (rst_in || w_latch) begin
            r_timeout_cnt <= 8'd0;
        end else if ((r_state == S_WAIT) && !dmem_ack_in) begin
            r_timeout_cnt <= w_cnt_next;
        end
    end
`endif

    assign dmem_req_o     = (r_state == S_WAIT);
    assign dmem_addr_o    = {r_word_addr, 2'b00};
    assign load_output_o  = r_load_output;
    assign load_valid_o   = r_load_valid;
    assign misaligned_o   = r_misaligned;
    assign access_fault_o = r_access_fault;
    assign stall_o        = (r_state == S_WAIT)
                          || (load_req_in && !w_misaligned && !flush_in);

endmodule
`default_nettype wire

// File: doc/load_unit.md
# load_unit

Load unit for the STRV32I datapath, sitting in the memory stage directly upstream of the writeback mux. Accepts a load request (address, size, signedness), runs a single-outstanding request/acknowledge transaction on the data-memory port, and extracts and extends the addressed byte, halfword or word. Its registered result drives the writeback mux's load-data input. It also reports misaligned and faulted loads.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16 — WAIT cycles without ack before a load is abandoned as a fault; only used when LOAD_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk_in  input  1  clock; all state updates on its rising edge.
- rst_in  input  1  synchronous, active-high reset.
- load_req_in  input  1  load request, sampled in IDLE only.
- load_size_in  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- load_unsigned_in  input  1  1 = zero-extend, 0 = sign-extend.
- addr_in  input  32  byte address.
- flush_in  input  1  kill the current or pending load.
- dmem_req_o  output  1  memory request; held until ack.
- dmem_addr_o  output  32  word-aligned address, i.e. {addr[31:2],2'b00}.
- dmem_ack_in  input  1  memory acknowledge; rdata and err are valid with it.
- dmem_rdata_in  input  32  memory read data.
- dmem_err_in  input  1  bus error, qualified by ack.
- load_output_o  output  32  extended load result, registered.
- load_valid_o  output  1  one-cycle pulse; load_output_o holds a new result.
- misaligned_o  output  1  one-cycle pulse on a misaligned or illegal-size request.
- access_fault_o  output  1  one-cycle pulse on a bus error or timeout.
- stall_o  output  1  combinational; asserted while the pipeline must hold.

## Operation
States: IDLE and WAIT.

Reset values:
- State is IDLE; all outputs except stall_o are 0.
- The kill flag and the timeout counter are 0.

Misalignment (IDLE, request present, flush_in=0):
- A request is misaligned if any of these holds: halfword with addr[0]=1; word with addr[1:0]≠0; size=11.
- Response: no bus request; misaligned_o pulses next cycle; load_output_o is unchanged; the unit stays in IDLE.

IDLE, aligned request, flush_in=0:
- Latch the address, addr[1:0], size and the unsigned flag, then go to WAIT.

WAIT:
- dmem_req_o=1, with dmem_addr_o stable.
- On dmem_ack_in=1 the unit returns to IDLE and dmem_req_o drops in the same edge.
- Normal completion: load_output_o is updated and load_valid_o pulses.
- If dmem_err_in=1 with the ack: load_output_o=0 and access_fault_o pulses; there is no valid pulse.

Data extraction:
- Byte lane = addr[1:0].
- Halfword lane = addr[1]: 0 selects [15:0], 1 selects [31:16].
- The selected field is extended to 32 bits, with zeros or copies of its MSB per the latched unsigned flag.

flush_in:
- In IDLE, flush wins over load_req_in: nothing is issued and there are no pulses.
- In WAIT, the bus handshake is never abandoned. The kill flag is set and dmem_req_o stays high until ack. At ack, the result is discarded: no valid pulse, no fault pulse, and load_output_o is unchanged. The kill flag clears on return to IDLE.

stall_o:
- 1 in WAIT.
- 1 in IDLE when load_req_in=1, the request is aligned and flush_in=0.
- 0 otherwise.

Reset mid-transaction:
- Returns the unit to IDLE.
- dmem_req_o is 0 from the next cycle.
- Any in-flight ack is ignored.

## Timing
- Request sampled in IDLE at edge N: dmem_req_o=1 after N.
- Ack sampled at edge M (M ≥ N+1): load_valid_o and data are valid after M, for exactly one cycle.
- With a zero-wait memory (ack on the first WAIT cycle), the result appears 2 cycles after the request.
- Back-to-back: a new request is accepted in the IDLE cycle right after completion, so throughput is one load per 2 cycles minimum.
- misaligned_o asserts one cycle after the offending request.

## Configuration
- LOAD_TIMEOUT_EN defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES: dmem_req_o drops, access_fault_o pulses (suppressed if the kill flag is set), load_output_o=0, state goes to IDLE.
  - An ack in the same cycle as expiry takes priority.
- LOAD_TIMEOUT_EN undefined: no counter; WAIT persists until ack.

## Test plan
- Signed byte: size=00, unsigned=0, addr=0x1003, rdata=0x80AB_CD12, ack on the first WAIT cycle → load_output_o=0xFFFF_FF80, valid 2 cycles after the request, dmem_addr_o=0x1000.
- Unsigned halfword with waits: size=01, unsigned=1, addr=0x2002, rdata=0x9876_5432, ack after 3 WAIT cycles → 0x0000_9876; dmem_req_o held 3 cycles.
- Misaligned word: size=10, addr=0x3001 → dmem_req_o stays 0, misaligned_o pulses once, stall_o=0.
- Flush in WAIT: flush_in=1 on the first WAIT cycle, ack 2 cycles later → no valid or fault pulse, load_output_o unchanged.
- Bus error: word at 0x4000, ack with err=1 → access_fault_o pulse, load_output_o=0.
- With LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → dmem_req_o drops after 4 WAIT cycles, then one access_fault_o pulse. Also apply rst_in mid-WAIT → IDLE and dmem_req_o=0 on the next cycle.
